// File: rtl/mwb_pipe_stage.sv
// Memory->Writeback pipeline register: DEPTH stages of {valid, ctrl, data}.
// It supports stall, flush and bubble gating, and keeps a count of retired instructions.
module mwb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("mwb_pipe_stage: DEPTH must be in 1..8");
        end
    endgenerate

    logic [DEPTH-1:0]             stage_v;
    logic [DEPTH-1:0][CTRL_W-1:0] stage_c;
    logic [DEPTH-1:0][DATA_W-1:0] stage_d;
    logic [CNT_W-1:0]             retire_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              v_reg;
            logic [CTRL_W-1:0] c_reg;
            logic [DATA_W-1:0] d_reg;
            logic              v_next;
            logic [CTRL_W-1:0] c_next;
            logic [DATA_W-1:0] d_next;

            if (gi == 0) begin : g_head
                // Bubbles enter with cleared control, so no write enable can leak downstream.
                assign v_next = in_valid;
                assign c_next = in_valid ? in_ctrl : '0;
                assign d_next = in_data;
            end else begin : g_body
                assign v_next = stage_v[gi-1];
                assign c_next = stage_c[gi-1];
                assign d_next = stage_d[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_reg <= 1'b0;
                    c_reg <= '0;
                    d_reg <= '0;
                end else if (flush) begin
                    // Payload is left alone on a kill; only valid and ctrl need clearing.
                    v_reg <= 1'b0;
                    c_reg <= '0;
                end else if (!stall) begin
                    v_reg <= v_next;
                    c_reg <= c_next;
                    d_reg <= d_next;
                end
            end

            assign stage_v[gi] = v_reg;
            assign stage_c[gi] = c_reg;
            assign stage_d[gi] = d_reg;
        end
    endgenerate

    // The oldest instruction commits on any unstalled edge, including a flush edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_reg <= '0;
        end else if (stage_v[DEPTH-1] && !stall) begin
            retire_reg <= retire_reg + CNT_W'(1);
        end
    end

    assign out_valid  = stage_v[DEPTH-1];
    assign out_ctrl   = stage_c[DEPTH-1];
    assign out_data   = stage_d[DEPTH-1];
    assign retire_cnt = retire_reg;

endmodule
